// File: rtl/aes_iter_decrypt.sv
// aes_iter_decrypt: iterative AES inverse cipher, one round per clock.
//
// Round keys are expanded in hardware into a local word store and kept there.
// A later block under the same key goes straight to the rounds and skips
// key expansion.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   decrypt request, accepted only while ready=1
//   ct_in   ciphertext [0:127], bits 0:7 = byte 0, sampled on the accepting edge
//   key_in  cipher key [0:KEY_LEN-1], sampled on the accepting edge
//   ready   high in IDLE only
//   done    one-cycle pulse, pt_out newly valid
//   pt_out  plaintext, held until the next done
//
// State   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; ready=1
// KEYEXP  | expanding one key word per cycle, i = NK .. 4*(NR+1)-1
// INIT    | state ^= rk[NR], load round counter with NR-1
// ROUND   | one full inverse round with rk[cnt], cnt counts down to 1
// FINAL   | last round without InvMixColumns using rk[0]; pulse done
module aes_iter_decrypt #(
  parameter int KEY_LEN = 128,
  parameter int NR      = 10,
  parameter int NK      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [0:127]       ct_in,
  input  logic [0:KEY_LEN-1] key_in,
  output logic               ready,
  output logic               done,
  output logic [0:127]       pt_out
);

  localparam int NW = 4 * (NR + 1);

  generate
    if (!((KEY_LEN == 128 && NR == 10 && NK == 4) ||
          (KEY_LEN == 192 && NR == 12 && NK == 6) ||
          (KEY_LEN == 256 && NR == 14 && NK == 8))) begin : g_bad_cfg
      $error("aes_iter_decrypt: unsupported (KEY_LEN, NR, NK) combination");
    end
  endgenerate

  // GF(2^8) helpers; the S-boxes are computed as inversion plus affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_INIT, S_ROUND, S_FINAL} state_t;

  state_t state, state_nxt;

  logic [127:0]       st;          // byte 0 sits in [127:120]
  logic [31:0]        w [NW];      // expanded key words, big-endian
  logic               key_valid;
  logic [5:0]         kidx;
  logic [2:0]         kmod;        // kidx mod NK
  logic [7:0]         rcon;
  logic [3:0]         cnt;

  logic [0:KEY_LEN-1] cached_key;
  logic               key_hit;

  // The first NK expanded words are the cipher key itself.
  always_comb begin
    cached_key = '0;
    for (int k = 0; k < NK; k++) cached_key[32*k +: 32] = w[k];
  end

  assign key_hit = key_valid && (key_in == cached_key);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = key_hit ? S_INIT : S_KEYEXP;
      end
      S_KEYEXP: if (kidx == 6'(NW - 1)) state_nxt = S_INIT;
      S_INIT:   state_nxt = S_ROUND;
      S_ROUND:  if (cnt == 4'd1) state_nxt = S_FINAL;
      S_FINAL:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Key expansion path: its own four forward S-boxes.
  logic [31:0] w_prev, w_back, sub_in, sub_out, temp, w_new;

  always_comb begin
    w_prev = w[kidx - 6'd1];
    w_back = w[kidx - 6'(NK)];
    sub_in = (kmod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = '0;
    for (int b = 0; b < 4; b++) sub_out[8*b +: 8] = sbox(sub_in[8*b +: 8]);
    if (kmod == 3'd0)                 temp = sub_out ^ {rcon, 24'h000000};
    else if (NK == 8 && kmod == 3'd4) temp = sub_out;
    else                              temp = w_prev;
    w_new = w_back ^ temp;
  end

  // Round datapath. rk index is NR in INIT; otherwise cnt, which has counted
  // down to 0 by the time FINAL is reached.
  logic [3:0]   rk_idx;
  logic [5:0]   rk_base;
  logic [127:0] rk, ark, imc;
  logic [7:0]   sb  [16];
  logic [7:0]   isr [16];
  logic [7:0]   isb [16];

  always_comb begin
    rk_idx  = (state == S_INIT) ? 4'(NR) : cnt;
    rk_base = {rk_idx, 2'b00};
    rk      = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    ark     = '0;
    imc     = '0;
    for (int n = 0; n < 16; n++) sb[n] = st[127 - 8*n -: 8];
    // byte n = 4*col + row; InvShiftRows moves row r right by r columns
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        isr[4*c + r] = sb[4*((c - r + 4) % 4) + r];
    for (int n = 0; n < 16; n++) begin
      isb[n] = inv_sbox(isr[n]);
      ark[127 - 8*n -: 8] = isb[n] ^ rk[127 - 8*n -: 8];
    end
    for (int c = 0; c < 4; c++) imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= '0;
      pt_out    <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      kidx      <= '0;
      kmod      <= '0;
      rcon      <= 8'h01;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            st <= ct_in;
            if (!key_hit) begin
              key_valid <= 1'b0;
              kidx      <= 6'(NK);
              kmod      <= '0;
              rcon      <= 8'h01;
            end
          end
        end
        S_KEYEXP: begin
          kidx <= kidx + 6'd1;
          kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0) rcon <= xtime(rcon);
          if (kidx == 6'(NW - 1)) key_valid <= 1'b1;
        end
        S_INIT: begin
          st  <= st ^ rk;
          cnt <= 4'(NR - 1);
        end
        S_ROUND: begin
          st  <= imc;
          cnt <= cnt - 4'd1;
        end
        S_FINAL: begin
          pt_out <= ark;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Key store carries no reset; key_valid guards its contents.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && !key_hit) begin
      for (int k = 0; k < NK; k++) w[k] <= key_in[32*k +: 32];
    end else if (state == S_KEYEXP) begin
      w[kidx] <= w_new;
    end
  end

endmodule

// File: tb/tb_aes_iter_decrypt.sv
module tb_aes_iter_decrypt;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [0:127] ct_in = '0;
  logic [0:127] key_a = '0;
  logic [0:191] key_b = '0;
  logic [0:255] key_c = '0;
  logic         ready_a, ready_b, ready_c;
  logic         done_a, done_b, done_c;
  logic [0:127] pt_a, pt_b, pt_c;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic         obs_ready, obs_done;
  logic [127:0] obs_pt;

  assign obs_ready = (cur == 0) ? ready_a : (cur == 1) ? ready_b : ready_c;
  assign obs_done  = (cur == 0) ? done_a  : (cur == 1) ? done_b  : done_c;
  assign obs_pt    = (cur == 0) ? pt_a    : (cur == 1) ? pt_b    : pt_c;

  always #5 clk = ~clk;

  aes_iter_decrypt #(.KEY_LEN(128), .NR(10), .NK(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ct_in(ct_in), .key_in(key_a),
    .ready(ready_a), .done(done_a), .pt_out(pt_a));
  aes_iter_decrypt #(.KEY_LEN(192), .NR(12), .NK(6)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ct_in(ct_in), .key_in(key_b),
    .ready(ready_b), .done(done_b), .pt_out(pt_b));
  aes_iter_decrypt #(.KEY_LEN(256), .NR(14), .NK(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .ct_in(ct_in), .key_in(key_c),
    .ready(ready_c), .done(done_c), .pt_out(pt_c));

  // key is left-aligned in 256 bits for the narrower instances
  task automatic drive(input int sel, input logic s, input logic [255:0] key,
                       input logic [127:0] ct);
    start_a = (sel == 0) && s;
    start_b = (sel == 1) && s;
    start_c = (sel == 2) && s;
    key_a   = key[255:128];
    key_b   = key[255:64];
    key_c   = key;
    ct_in   = ct;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called one time unit after a rising edge with the instance idle.
  task automatic run_block(input int sel, input logic [255:0] key, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input int exp_lat, input bit noisy,
                           input string tag);
    int n;
    bit seen;
    bit ready_bad;
    logic [255:0] r;
    cur = sel;
    drive(sel, 1'b1, key, ct);
    @(posedge clk); #1;
    ready_bad = (obs_ready !== 1'b0);
    r = rnd256();
    drive(sel, noisy, r, r[127:0]);
    seen = 0;
    n = 0;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (obs_done === 1'b1) seen = 1;
      else begin
        if (obs_ready !== 1'b0) ready_bad = 1;
        r = rnd256();
        drive(sel, noisy && (n < exp_lat), r, r[127:0]);
      end
    end
    drive(sel, 1'b0, '0, '0);
    checks++;
    assert (seen === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout: no done after %0d edges, required done at %0d", tag, n, exp_lat);
    end
    if (seen) begin
      checks++;
      assert (n === exp_lat) else begin
        errors++;
        $error("FAIL %s_latency: got %0d edges, required %0d", tag, n, exp_lat);
      end
      checks++;
      assert (obs_pt === exp_pt) else begin
        errors++;
        $error("FAIL %s_pt: got %h, required %h", tag, obs_pt, exp_pt);
      end
      checks++;
      assert (obs_ready === 1'b1) else begin
        errors++;
        $error("FAIL %s_ready_at_done: got %b, required 1", tag, obs_ready);
      end
    end
    checks++;
    assert (ready_bad === 1'b0) else begin
      errors++;
      $error("FAIL %s_ready_busy: ready seen high while busy, required 0", tag);
    end
    @(posedge clk); #1;
    checks++;
    assert (obs_done === 1'b0 && obs_pt === exp_pt) else begin
      errors++;
      $error("FAIL %s_pulse: done=%b pt=%h, required done=0 pt=%h", tag, obs_done, obs_pt, exp_pt);
    end
  endtask

  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KFIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] hold;
    bit idle_bad;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (ready_a === 1'b1 && done_a === 1'b0) else begin
      errors++;
      $error("FAIL reset_ctrl: ready=%b done=%b, required ready=1 done=0", ready_a, done_a);
    end
    checks++;
    assert (pt_a === 128'h0 && pt_b === 128'h0 && pt_c === 128'h0) else begin
      errors++;
      $error("FAIL reset_pt: got %h/%h/%h, required zero", pt_a, pt_b, pt_c);
    end
    checks++;
    assert ({ready_b, ready_c, done_b, done_c} === 4'b1100) else begin
      errors++;
      $error("FAIL reset_bc: got %b, required 1100", {ready_b, ready_c, done_b, done_c});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(0, {K128, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 51, 0, "aes128_cold");
    run_block(1, {K192, 64'h0},  128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT, 59, 0, "aes192_cold");
    run_block(2, K256,           128'h8ea2b7ca516745bfeafc49904b496089, PT, 67, 0, "aes256_cold");
    run_block(0, {K128, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 11, 0, "aes128_cached");
    run_block(0, {KFIPS, 128'h0}, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 51, 0, "aes128_newkey");
    run_block(0, {K128, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 51, 1, "busy_noise");

    // Abort the cached-key block in the middle of its rounds.
    cur = 0;
    drive(0, 1'b1, {K128, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (ready_a === 1'b1 && done_a === 1'b0 && pt_a === 128'h0) else begin
      errors++;
      $error("FAIL midreset: ready=%b done=%b pt=%h, required 1/0/0", ready_a, done_a, pt_a);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block(0, {K128, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT, 51, 0, "after_reset");

    hold = obs_pt;
    idle_bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_a !== 1'b0 || pt_a !== hold) idle_bad = 1;
    end
    checks++;
    assert (idle_bad === 1'b0 && pt_a === PT) else begin
      errors++;
      $error("FAIL idle_hold: pt=%h changed or done seen, required %h steady", pt_a, PT);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
